// File: rtl/uart_core_p.sv
// uart_core_p: UART with runtime baud divisor, 5..8 data bits, optional parity,
// 1/2 stop bits, TX/RX FIFOs with per-word RX error flags, sticky overrun
// detection and RTS/CTS flow control.

// Synchronous FIFO, first-word fall-through, registered occupancy.
module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_rd   = rd_en && !empty;
  // A write at full still lands when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      level <= level + LW'(1);
      else if (do_rd && !do_wr) level <= level - LW'(1);
    end
  end

  // Storage array write port.
  // NOTE: the array is not reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

module uart_core_p #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int RTS_MARGIN = 4,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 cts_n,
  output logic                 rts_n,
  input  logic                 tx_wr_en,
  input  logic [DATA_BITS-1:0] tx_wr_data,
  output logic                 tx_full,
  output logic [LW-1:0]        tx_level,
  output logic                 tx_busy,
  input  logic                 rx_rd_en,
  output logic [DATA_BITS-1:0] rx_rd_data,
  output logic [1:0]           rx_rd_err,
  output logic                 rx_empty,
  output logic [LW-1:0]        rx_level,
  output logic                 overrun,
  input  logic                 overrun_clr
);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] baud_cnt;
  logic             tick;
  assign tick = (baud_cnt >= baud_div);

  // Oversample counter: one tick every baud_div+1 clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + DIV_W'(1);
  end

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_state_d;
  logic [4:0]           tx_tcnt, tx_tcnt_d, tx_last;
  logic [2:0]           tx_bit, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_d, tx_head;
  logic                 tx_par, tx_par_d, tx_pen, tx_pen_d, tx_st2, tx_st2_d;
  logic                 tx_pop, tx_empty, tx_d;

  uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr_en(tx_wr_en), .wr_data(tx_wr_data),
    .rd_en(tx_pop), .rd_data(tx_head), .full(tx_full), .empty(tx_empty),
    .level(tx_level)
  );

  assign tx_last = (tx_state == TX_STOP && tx_st2) ? 5'd31 : 5'd15;
  assign tx_busy = (tx_state != TX_IDLE);

  // TX next-state: frame start on a tick, then 16 ticks per bit slot.
  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    tx_state_d = tx_state;
    tx_tcnt_d  = tx_tcnt;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_par_d   = tx_par;
    tx_pen_d   = tx_pen;
    tx_st2_d   = tx_st2;
    tx_pop     = 1'b0;
    if (tick) begin
      if (tx_state == TX_IDLE) begin
        // Flow control and config are looked at only here, at frame start.
        if (!tx_empty && !cts_n) begin
          tx_pop     = 1'b1;
          tx_state_d = TX_START;
          tx_tcnt_d  = '0;
          tx_bit_d   = '0;
          tx_sh_d    = tx_head;
          tx_par_d   = (^tx_head) ^ parity_odd;
          tx_pen_d   = parity_en;
          tx_st2_d   = stop2;
        end
      end else if (tx_tcnt != tx_last) begin
        tx_tcnt_d = tx_tcnt + 5'd1;
      end else begin
        tx_tcnt_d = '0;
        case (tx_state)
          TX_START:  tx_state_d = TX_DATA;
          TX_DATA: begin
            if (tx_bit == LAST_BIT) begin
              tx_state_d = tx_pen ? TX_PARITY : TX_STOP;
            end else begin
              tx_bit_d = tx_bit + 3'd1;
              tx_sh_d  = tx_sh >> 1;
            end
          end
          TX_PARITY: tx_state_d = TX_STOP;
          default:   tx_state_d = TX_IDLE;
        endcase
      end
    end
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_sh_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // TX state register; the line itself is registered to keep the pad glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_pen   <= 1'b0;
      tx_st2   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_tcnt  <= tx_tcnt_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      tx_par   <= tx_par_d;
      tx_pen   <= tx_pen_d;
      tx_st2   <= tx_st2_d;
      tx       <= tx_d;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state, rx_state_d;
  logic                 rx_s1, rx_s2;
  logic [3:0]           rx_tcnt, rx_tcnt_d;
  logic [2:0]           rx_bit, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_d;
  logic                 rx_perr, rx_perr_d, rx_pen, rx_pen_d, rx_odd, rx_odd_d;
  logic                 rx_push, rx_full;
  logic [DATA_BITS+1:0] rx_head;

  // RX next-state: mid-bit sampling 16 ticks apart after a validated start.
  always_comb begin
    rx_state_d = rx_state;
    rx_tcnt_d  = rx_tcnt;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_perr_d  = rx_perr;
    rx_pen_d   = rx_pen;
    rx_odd_d   = rx_odd;
    rx_push    = 1'b0;
    case (rx_state)
      RX_IDLE: if (tick && !rx_s2) begin
        rx_state_d = RX_START;
        rx_tcnt_d  = '0;
        rx_perr_d  = 1'b0;
        rx_pen_d   = parity_en;
        rx_odd_d   = parity_odd;
      end
      RX_START: if (tick) begin
        if (rx_tcnt == 4'd7) begin
          rx_tcnt_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_tcnt_d = rx_tcnt + 4'd1;
        end
      end
      RX_DATA, RX_PARITY, RX_STOP: if (tick) begin
        rx_tcnt_d = rx_tcnt + 4'd1;
        if (rx_tcnt == 4'd15) begin
          if (rx_state == RX_DATA) begin
            rx_sh_d = {rx_s2, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) rx_state_d = rx_pen ? RX_PARITY : RX_STOP;
            else                    rx_bit_d   = rx_bit + 3'd1;
          end else if (rx_state == RX_PARITY) begin
            rx_perr_d  = rx_s2 ^ (^rx_sh) ^ rx_odd;
            rx_state_d = RX_STOP;
          end else begin
            rx_push    = 1'b1;
            rx_state_d = rx_s2 ? RX_IDLE : RX_BREAK;
          end
        end
      end
      RX_BREAK: if (rx_s2) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // RX synchroniser and state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_perr  <= 1'b0;
      rx_pen   <= 1'b0;
      rx_odd   <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_d;
      rx_tcnt  <= rx_tcnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
      rx_perr  <= rx_perr_d;
      rx_pen   <= rx_pen_d;
      rx_odd   <= rx_odd_d;
    end
  end

  uart_fifo #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr_en(rx_push),
    .wr_data({!rx_s2, rx_perr, rx_sh}),
    .rd_en(rx_rd_en), .rd_data(rx_head), .full(rx_full), .empty(rx_empty),
    .level(rx_level)
  );
  assign rx_rd_err  = rx_head[DATA_BITS+1:DATA_BITS];
  assign rx_rd_data = rx_head[DATA_BITS-1:0];

  // Sticky overrun (set beats clear) and registered RTS from free space.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
      rts_n   <= 1'b0;
    end else begin
      if (rx_push && rx_full && !rx_rd_en) overrun <= 1'b1;
      else if (overrun_clr)                overrun <= 1'b0;
      rts_n <= ((LW'(FIFO_DEPTH) - rx_level) <= LW'(RTS_MARGIN));
    end
  end
endmodule

// File: tb/tb_uart_core_p.sv
// Self-checking bench for uart_core_p: loopback and bench-driven RX frames,
// expected RX words queued at stimulus time and compared on arrival.
module tb_uart_core_p;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, stop2;
  logic        rx, tx, cts_n, rts_n;
  logic        tx_wr_en, tx_full, tx_busy;
  logic [7:0]  tx_wr_data, rx_rd_data;
  logic [4:0]  tx_level, rx_level;
  logic        rx_rd_en, rx_empty, overrun, overrun_clr;
  logic [1:0]  rx_rd_err;
  logic        loop, rx_drv;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [9:0]  exp_q[$];
  logic [7:0]  d_v;
  bit          seen_v;
  int          low_v;

  uart_core_p dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .rx(rx), .tx(tx), .cts_n(cts_n),
    .rts_n(rts_n), .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
    .tx_full(tx_full), .tx_level(tx_level), .tx_busy(tx_busy),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_rd_err(rx_rd_err),
    .rx_empty(rx_empty), .rx_level(rx_level), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;
  assign rx = loop ? tx : rx_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_wr_data = d;
    tx_wr_en   = 1'b1;
    @(negedge clk);
    tx_wr_en   = 1'b0;
  endtask

  task automatic wait_tx_low(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Counts clocks with tx low over a window; expected 0 when TX is withheld.
  task automatic count_tx_low(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      if (tx === 1'b0) lows++;
      @(negedge clk);
    end
  endtask

  // Checks one transmitted frame bit by bit at mid-bit (baud_div=0, d[0]=1).
  task automatic tx_frame_check(input logic [7:0] d, input bit pen, input logic pbit);
    bit seen;
    int low;
    wait_tx_low(seen);
    check("tx_start_seen", seen, 1);
    if (seen) begin
      low = 0;
      while (tx === 1'b0 && low < 100) begin
        low++;
        @(negedge clk);
      end
      check("tx_start_len", low, 16);
      cycles(8);
      for (int k = 0; k < 8; k++) begin
        check($sformatf("tx_d%0d", k), tx, d[k]);
        cycles(16);
      end
      if (pen) begin
        check("tx_parity", tx, pbit);
        cycles(16);
      end
      check("tx_stop", tx, 1);
    end
  endtask

  // Bench-driven RX frame, 16 clocks per bit; a good stop bit is followed by idle.
  task automatic send_frame(input logic [7:0] d, input bit pen, input logic pbit,
                            input logic stop_bit);
    rx_drv = 1'b0;
    cycles(16);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      cycles(16);
    end
    if (pen) begin
      rx_drv = pbit;
      cycles(16);
    end
    rx_drv = stop_bit;
    cycles(16);
    if (stop_bit) cycles(16);
  endtask

  // Pops the scoreboard head and compares it with the RX FIFO head.
  task automatic drain_one();
    bit         seen;
    logic [9:0] e;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (rx_empty === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rx_avail", seen, 1);
    e = exp_q.pop_front();
    if (seen) begin
      check("rx_word", {rx_rd_err, rx_rd_data}, e);
      rx_rd_en = 1'b1;
      @(negedge clk);
      rx_rd_en = 1'b0;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; baud_div = '0; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    cts_n = 1'b0; tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0;
    overrun_clr = 1'b0; loop = 1'b0; rx_drv = 1'b1;
    cycles(3);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_rts", rts_n, 0);
    check("rst_ovr", overrun, 0);
    check("rst_txfull", tx_full, 0);
    check("rst_rxempty", rx_empty, 1);
    check("rst_txlvl", tx_level, 0);
    check("rst_rxlvl", rx_level, 0);
    reset = 1'b1;
    cycles(5);

    // 8N1 loopback.
    loop = 1'b1;
    push_tx(8'hA5);
    exp_q.push_back({2'b00, 8'hA5});
    tx_frame_check(8'hA5, 1'b0, 1'b0);
    cycles(16);
    check("rx_lvl_one", rx_level, 1);
    drain_one();

    // 8O1 loopback, then bench frame with the wrong parity bit.
    parity_en = 1'b1; parity_odd = 1'b1;
    d_v = 8'h03;
    push_tx(d_v);
    exp_q.push_back({2'b00, d_v});
    tx_frame_check(d_v, 1'b1, (^d_v) ^ 1'b1);
    cycles(16);
    drain_one();
    cycles(40);
    loop = 1'b0;
    cycles(20);
    send_frame(d_v, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({2'b01, d_v});
    drain_one();
    parity_en = 1'b0; parity_odd = 1'b0;

    // Slower baud and two stop bits, back-to-back loopback words.
    baud_div = 16'd2; stop2 = 1'b1; loop = 1'b1;
    push_tx(8'h3C); push_tx(8'h81); push_tx(8'h7E);
    exp_q.push_back({2'b00, 8'h3C});
    exp_q.push_back({2'b00, 8'h81});
    exp_q.push_back({2'b00, 8'h7E});
    repeat (3) drain_one();
    cycles(200);
    baud_div = '0; stop2 = 1'b0; loop = 1'b0;
    cycles(20);

    // Fill the RX FIFO, watch RTS, then overflow it.
    for (int i = 0; i < 16; i++) begin
      d_v = 8'(i * 13 + 5);
      send_frame(d_v, 1'b0, 1'b0, 1'b1);
      exp_q.push_back({2'b00, d_v});
      if (i == 10) check("rts_lvl11", rts_n, 0);
      if (i == 11) begin
        check("lvl12", rx_level, 12);
        check("rts_lvl12", rts_n, 1);
      end
    end
    check("lvl16", rx_level, 16);
    check("ovr_pre", overrun, 0);
    send_frame(8'hEE, 1'b0, 1'b0, 1'b1);
    check("ovr_set", overrun, 1);
    check("lvl_after_ovr", rx_level, 16);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    while (exp_q.size() > 0) drain_one();
    check("rx_empty_after_drain", rx_empty, 1);
    cycles(2);
    check("rts_after_drain", rts_n, 0);

    // CTS flow control.
    loop = 1'b1; cts_n = 1'b1;
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    count_tx_low(200, low_v);
    check("cts_hold_tx", low_v, 0);
    check("cts_txlvl3", tx_level, 3);
    check("cts_idle", tx_busy, 0);
    exp_q.push_back({2'b00, 8'h11});
    cts_n = 1'b0;
    wait_tx_low(seen_v);
    check("cts_start_seen", seen_v, 1);
    check("cts_txlvl2", tx_level, 2);
    cycles(60);
    cts_n = 1'b1;
    drain_one();
    seen_v = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (tx_busy === 1'b0) begin
        seen_v = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("cts_frame_done", seen_v, 1);
    count_tx_low(300, low_v);
    check("cts_withheld", low_v, 0);
    check("cts_txlvl_hold", tx_level, 2);
    cts_n = 1'b0;
    exp_q.push_back({2'b00, 8'h22});
    exp_q.push_back({2'b00, 8'h33});
    drain_one();
    drain_one();
    cycles(100);

    // Framing error followed by a long break.
    loop = 1'b0;
    cycles(20);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    cycles(40 * 16);
    exp_q.push_back({2'b10, 8'h5A});
    check("brk_lvl", rx_level, 1);
    drain_one();
    cycles(100);
    check("brk_no_more", rx_empty, 1);
    rx_drv = 1'b1;
    cycles(100);
    check("brk_release", rx_empty, 1);

    // Short glitch is rejected; a real frame after it is kept unread.
    rx_drv = 1'b0;
    cycles(4);
    rx_drv = 1'b1;
    cycles(300);
    check("glitch_no_word", rx_empty, 1);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1);
    check("post_glitch_lvl", rx_level, 1);
    check("post_glitch_data", rx_rd_data, 8'h96);

    // Reset asserted while a frame is on the line.
    loop = 1'b1;
    push_tx(8'h5B); push_tx(8'h6C);
    wait_tx_low(seen_v);
    check("mid_start_seen", seen_v, 1);
    cycles(5);
    reset = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_rxempty", rx_empty, 1);
    check("mid_rst_rts", rts_n, 0);
    check("mid_rst_txlvl", tx_level, 0);
    check("mid_rst_rxlvl", rx_level, 0);
    @(negedge clk);
    reset = 1'b1;
    count_tx_low(400, low_v);
    check("post_rst_tx_quiet", low_v, 0);
    check("post_rst_no_word", rx_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_core_p.md
Name: uart_core_p

Overview:
- Parametrised next-generation UART core: runtime baud divisor, configurable data bits, parity, 1 or 2 stop bits, TX and RX FIFOs of parametrised depth.
- RX FIFO stores per-word error flags. Adds sticky overrun detection and RTS/CTS hardware flow control.
- Sits between the pads (rx/tx/cts_n/rts_n) and an application or bus-register block; replaces the fixed 8-bit/16-deep UART top.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..8.
- FIFO_DEPTH, 16, entries per FIFO; power of 2, ≥4.
- DIV_W, 16, width of baud_div.
- RTS_MARGIN, 4, rts_n deasserts when RX free slots ≤ RTS_MARGIN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- baud_div  in  DIV_W  clocks per oversample tick minus 1; bit period = 16 ticks
- parity_en  in  1  1 = parity bit present
- parity_odd  in  1  1 = odd parity, 0 = even
- stop2  in  1  1 = two stop bits on TX
- rx  in  1  serial input (asynchronous)
- tx  out  1  serial output
- cts_n  in  1  0 = peer may receive
- rts_n  out  1  0 = we may receive
- tx_wr_en  in  1  push tx_wr_data
- tx_wr_data  in  DATA_BITS  byte to send
- tx_full  out  1  TX FIFO full
- tx_level  out  clog2(FIFO_DEPTH)+1  TX occupancy
- tx_busy  out  1  TX FSM not IDLE
- rx_rd_en  in  1  pop RX head
- rx_rd_data  out  DATA_BITS  RX head data (first-word fall-through)
- rx_rd_err  out  2  head flags {frame_err, parity_err}
- rx_empty  out  1  RX FIFO empty
- rx_level  out  clog2(FIFO_DEPTH)+1  RX occupancy
- overrun  out  1  sticky: RX word dropped
- overrun_clr  in  1  clear overrun

Behaviour:
- Reset (async, active-low): FIFOs empty; tx=1, tx_busy=0, rts_n=0, overrun=0, tx_full=0, rx_empty=1, levels=0; rx synchroniser flops=1; both FSMs IDLE; baud counter=0.
- Baud gen: counter 0..baud_div, 1-cycle tick when count==baud_div, then reload 0. baud_div=0 gives a tick every clk. Config changes apply to the next frame only; changing them mid-frame is undefined.
- FIFOs: write when full is ignored (no change). Read when empty is ignored; data holds. Simultaneous read+write keeps level unchanged, including at full; both pointers wrap modulo FIFO_DEPTH.
- TX FSM: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when FIFO non-empty and cts_n==0, sampled on a tick; the head is popped that cycle.
  - Each state holds 16 ticks. tx=0 in START. DATA sends LSB first, DATA_BITS bits.
  - PARITY (only if parity_en) = XOR(data) ^ parity_odd.
  - STOP holds tx=1 for 16 or 32 ticks.
  - cts_n is checked only at frame start; a deassert mid-frame does not abort the frame.
- RX: rx passes through a 2-flop synchroniser. RX FSM: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE → START on synced rx==0 at a tick.
  - START: at tick 7 (mid-bit), rx==0 → DATA; otherwise glitch → IDLE with no write.
  - DATA/PARITY: sample at the 16th tick after the previous sample.
  - STOP: sample one stop bit only. Frame_err = sampled 0; parity_err = mismatch (0 if !parity_en).
  - At the stop sample, write {frame_err, parity_err, data} and go to IDLE, or to BREAK if frame_err. BREAK waits for synced rx==1 before returning to IDLE.
- Overrun: if the RX write occurs while full and there is no same-cycle pop, the word is dropped and overrun is set. overrun_clr clears it; if a set and clear occur in the same cycle, set wins.
- rts_n: registered; 1 when (FIFO_DEPTH − rx_level) ≤ RTS_MARGIN, else 0; updates 1 cycle after level change.
- Level outputs are registered and consistent with full/empty in the same cycle.

Test Plan:
- Reset held low mid-frame (tx=0) → tx=1 immediately, tx_busy=0, rx_empty=1, rts_n=0, levels=0; no stale word after release.
- 8N1, baud_div=0, push 0xA5 with tx looped to rx → tx=0 for 16 clks, then bits 1,0,1,0,0,1,0,1 each 16 clks, stop=1. Frame is 160 clks; rx_rd_data=0xA5, rx_rd_err=00, rx_level=1.
- 8O1, push 0x03 → parity bit 1 on line. Bench drives the same frame with parity 0 → rx_rd_err=01, data 0x03.
- Drive 16 frames with no reads → rx_level=16, rts_n=1 after level 12. 17th frame → overrun=1, level stays 16, 17th word absent. Pulse overrun_clr → overrun=0.
- cts_n=1 with 3 words queued → tx stays 1, tx_level=3. Release cts_n → first frame starts; raise cts_n mid-frame → that frame completes, next frame withheld.
- Drive frame with stop=0 then rx held 0 for 40 bit times → one word with rx_rd_err=10, no further words until rx returns 1. Drive a 4-tick low glitch → no word written.
